// File: rtl/i2c_init_sequencer_if.sv
// AXI write-channel bundle between the init sequencer (master) and the I2C controller window (slave).
// Only the AW, W and B channels are carried; the sequencer never reads.
interface i2c_init_sequencer_if;
  logic [3:0]  MASTER_WR_ADDR_ID;
  logic [31:0] MASTER_WR_ADDR;
  logic [7:0]  MASTER_WR_ADDR_LEN;
  logic [1:0]  MASTER_WR_ADDR_BURST;
  logic        MASTER_WR_ADDR_VALID;
  logic        MASTER_WR_ADDR_READY;
  logic [31:0] MASTER_WR_DATA;
  logic [3:0]  MASTER_WR_STRB;
  logic        MASTER_WR_DATA_LAST;
  logic        MASTER_WR_DATA_VALID;
  logic        MASTER_WR_DATA_READY;
  logic [3:0]  MASTER_WR_BACK_ID;
  logic [1:0]  MASTER_WR_BACK_RESP;
  logic        MASTER_WR_BACK_VALID;
  logic        MASTER_WR_BACK_READY;

  modport master (
    output MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
    output MASTER_WR_ADDR_VALID,
    input  MASTER_WR_ADDR_READY,
    output MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID,
    input  MASTER_WR_DATA_READY,
    input  MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
    output MASTER_WR_BACK_READY
  );

  modport slave (
    input  MASTER_WR_ADDR_ID, MASTER_WR_ADDR, MASTER_WR_ADDR_LEN, MASTER_WR_ADDR_BURST,
    input  MASTER_WR_ADDR_VALID,
    output MASTER_WR_ADDR_READY,
    input  MASTER_WR_DATA, MASTER_WR_STRB, MASTER_WR_DATA_LAST, MASTER_WR_DATA_VALID,
    output MASTER_WR_DATA_READY,
    output MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
    input  MASTER_WR_BACK_READY
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Walks a register-init table and issues one single-beat AXI write per entry, with retries and a post-write gap.
// One outstanding write at a time; AW, W and B each wait indefinitely on the slave's ready/valid.
module i2c_init_sequencer #(
  parameter logic [31:0] OFFSET_ADDR = 32'h0000_0000,
  parameter int          TABLE_DEPTH = 64,
  parameter int          MAX_RETRY   = 3,
  parameter logic [31:0] GAP_CYCLES  = 32'd250000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [7:0]                   fail_index,
  output logic [7:0]                   tbl_addr,
  input  logic [31:0]                  tbl_data,
  i2c_init_sequencer_if.master         axi
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, AW, W, B, GAP, FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] entry_q, entry_d;
  logic [8:0]  index_q, index_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0] gap_q, gap_d;
  logic        error_q, error_d;
  logic [7:0]  fail_q, fail_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      entry_q <= '0;
      index_q <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      error_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      index_q <= index_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      error_q <= error_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    index_d = index_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    error_d = error_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          index_d = '0;
          retry_d = '0;
          error_d = 1'b0;
          fail_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        entry_d = tbl_data;
        if (tbl_data == 32'hFFFF_FFFF || index_q == 9'(TABLE_DEPTH)) state_d = FIN;
        else state_d = AW;
      end
      AW: if (axi.MASTER_WR_ADDR_READY) state_d = W;
      W:  if (axi.MASTER_WR_DATA_READY) state_d = B;
      B: begin
        if (axi.MASTER_WR_BACK_VALID) begin
          if (axi.MASTER_WR_BACK_RESP == 2'b00) begin
            retry_d = '0;
            gap_d   = GAP_CYCLES;
            state_d = GAP;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = AW;
          end else begin
            // Give up on this entry but keep walking; only the first failure is recorded.
            if (!error_q) fail_d = index_q[7:0];
            error_d = 1'b1;
            retry_d = '0;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          index_d = index_q + 9'd1;
          state_d = FETCH;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode straight from state so reset clears them without waiting for a clock.
  assign busy       = (state_q != IDLE) && (state_q != FIN);
  assign done       = (state_q == FIN);
  assign error      = error_q;
  assign fail_index = fail_q;
  assign tbl_addr   = (state_q == FETCH) ? index_q[7:0] : 8'h00;

  assign axi.MASTER_WR_ADDR_ID    = 4'h0;
  assign axi.MASTER_WR_ADDR_LEN   = 8'h00;
  assign axi.MASTER_WR_ADDR_VALID = (state_q == AW);
  assign axi.MASTER_WR_ADDR_BURST = (state_q == AW) ? 2'b01 : 2'b00;
  assign axi.MASTER_WR_ADDR       = (state_q == AW) ? (OFFSET_ADDR + {8'h00, entry_q[31:8]}) : 32'h0;

  assign axi.MASTER_WR_DATA_VALID = (state_q == W);
  assign axi.MASTER_WR_DATA       = (state_q == W) ? {24'h0, entry_q[7:0]} : 32'h0;
  assign axi.MASTER_WR_STRB       = (state_q == W) ? 4'b0001 : 4'b0000;
  assign axi.MASTER_WR_DATA_LAST  = (state_q == W);

  assign axi.MASTER_WR_BACK_READY = (state_q == B);

  logic unused_bid;
  assign unused_bid = ^axi.MASTER_WR_BACK_ID;

endmodule
